prng_arbiter: RTL and testbench

Controller that owns one shared PRNG core (`lcg_prng`, `mt8_prng` or `lfsr`, all with the `load_seed`/`seed_data`/`prng_data`/`prng_done` port set) and multiplexes its output among several requesters. It sequences seeding, buffers one fresh core value at a time, and hands each value to exactly one requester under round-robin arbitration. Blocks that need randomness connect here instead of instantiating their own PRNG.

---
 rtl/prng_arbiter_if.sv | 14 +
 rtl/prng_arbiter.sv | 101 ++++++++++
 tb/tb_prng_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/prng_arbiter_if.sv
// prng_arbiter_if: seed handshake plus request/grant/data bus between requesters and prng_arbiter.
interface prng_arbiter_if #(
  parameter int N = 8,
  parameter int NUM_REQ = 4
);
  logic seed_valid;
  logic [N-1:0] seed_data;
  logic seed_ready;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [N-1:0] rnd_data;
  modport master (output seed_valid, seed_data, req, input seed_ready, gnt, rnd_data);
  modport slave (input seed_valid, seed_data, req, output seed_ready, gnt, rnd_data);
endinterface

// File: rtl/prng_arbiter.sv
// prng_arbiter: shares one PRNG core among NUM_REQ requesters with round-robin grants.
// Defining PRNG_ARB_RESEED_EN adds an automatic reseed every RESEED_PERIOD grants.
module prng_arbiter #(
  parameter int N = 8,
  parameter int NUM_REQ = 4,
  parameter int RESEED_PERIOD = 256
) (
  input  logic clk,
  input  logic reset,
  prng_arbiter_if.slave bus,
  output logic seeded,
  output logic [15:0] grant_count,
  output logic core_load_seed,
  output logic [N-1:0] core_seed_data,
  input  logic [N-1:0] core_prng_data,
  input  logic core_prng_done
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
  state_t state, state_n;
  logic [N-1:0] ld_seed, next_seed, buf_data;
  logic buf_full, seed_hs, auto_rs, grant, found;
  logic [PW-1:0] ptr, win;
  logic [NUM_REQ-1:0] elig;
  int j;
  assign bus.seed_ready = !reset && state != LOAD;
  assign seed_hs = bus.seed_valid && bus.seed_ready;
  // a requester's own req is ignored while its grant pulse is out
  assign elig = bus.req & ~bus.gnt;
  assign grant = state == RUN && buf_full && found && !seed_hs && !auto_rs;
  assign core_load_seed = state == LOAD;
  assign core_seed_data = core_load_seed ? ld_seed : '0;
`ifdef PRNG_ARB_RESEED_EN
  logic [31:0] since;
  logic [N-1:0] base, idx;
  assign auto_rs = state == RUN && since == 32'(RESEED_PERIOD);
  assign next_seed = seed_hs ? bus.seed_data : base + idx + 1'b1;
  always_ff @(posedge clk)
    if (reset) begin
      since <= '0;
      base <= '0;
      idx <= '0;
    end else begin
      since <= state == LOAD ? '0 : since + 32'(grant);
      if (seed_hs) begin
        base <= bus.seed_data;
        idx <= '0;
      end else if (auto_rs) idx <= idx + 1'b1;
    end
`else
  logic unused_period;
  assign unused_period = ^RESEED_PERIOD;
  assign auto_rs = 1'b0;
  assign next_seed = bus.seed_data;
`endif
  always_comb begin
    found = 1'b0;
    win = '0;
    j = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && elig[PW'(j)]) begin
        found = 1'b1;
        win = PW'(j);
      end
    end
  end
  always_comb begin
    state_n = state;
    state_n = (seed_hs || auto_rs) ? LOAD : (state == LOAD ? RUN : state);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (reset) begin
      bus.gnt <= '0;
      bus.rnd_data <= '0;
      buf_full <= 1'b0;
      buf_data <= '0;
      ptr <= '0;
      seeded <= 1'b0;
      grant_count <= '0;
      ld_seed <= '0;
    end else begin
      bus.gnt <= grant ? (NUM_REQ'(1) << win) : '0;
      bus.rnd_data <= grant ? buf_data : '0;
      if (grant) begin
        ptr <= win == PW'(NUM_REQ - 1) ? '0 : win + 1'b1;
        grant_count <= grant_count + 16'd1;
      end
      // an unconsumed value is overwritten by a newer one; consume+refill keeps it full
      if (state == LOAD) begin
        buf_full <= 1'b0;
        seeded <= 1'b1;
      end else if (state == RUN) buf_full <= core_prng_done || (buf_full && !grant);
      if (state == RUN && core_prng_done) buf_data <= core_prng_data;
      if (seed_hs || auto_rs) ld_seed <= next_seed == '0 ? N'(1) : next_seed;
    end
endmodule

// File: tb/tb_prng_arbiter.sv
// tb_prng_arbiter: random and directed stimulus against a queue-based reference model with an LCG core stand-in.
module tb_prng_arbiter;
  localparam int N = 8;
  localparam int NR = 4;
`ifdef PRNG_ARB_RESEED_EN
  localparam int RP = 4;
`else
  localparam int RP = 256;
`endif
  logic clk = 1'b0;
  logic reset, seeded, core_load_seed, core_prng_done;
  logic [15:0] grant_count;
  logic [N-1:0] core_seed_data, core_prng_data;
  prng_arbiter_if #(.N(N), .NUM_REQ(NR)) bus ();
  prng_arbiter #(.N(N), .NUM_REQ(NR), .RESEED_PERIOD(RP)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .seeded(seeded),
    .grant_count(grant_count),
    .core_load_seed(core_load_seed),
    .core_seed_data(core_seed_data),
    .core_prng_data(core_prng_data),
    .core_prng_done(core_prng_done)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  int m_mode, m_ptr, m_gnt, m_rnd, m_seeded, m_gc, m_lseed, m_base, m_idx, m_since;
  int q_buf[$];
  int got[$];
  int loads[$];
  int c_state = 0;
  int cyc = 0;
  int done_every = 1;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int lcg(input int x);
    return (x * 5 + 3) & 255;
  endfunction
  task automatic model_edge(input logic s_reset, input logic s_sv, input logic [N-1:0] s_sd,
                            input logic [NR-1:0] s_req, input logic s_done, input logic [N-1:0] s_pd);
    int hs, ars, elig, w;
    if (s_reset) begin
      m_mode = 0; q_buf.delete(); m_ptr = 0; m_gnt = 0; m_rnd = 0; m_seeded = 0;
      m_gc = 0; m_lseed = 0; m_base = 0; m_idx = 0; m_since = 0;
    end else begin
      hs = int'(s_sv && m_mode != 1);
`ifdef PRNG_ARB_RESEED_EN
      ars = int'(m_mode == 2 && m_since == RP);
`else
      ars = 0;
`endif
      elig = int'(s_req) & ~m_gnt;
      m_gnt = 0;
      m_rnd = 0;
      if (m_mode == 2 && q_buf.size() > 0 && elig != 0 && hs == 0 && ars == 0) begin
        w = -1;
        for (int i = 0; i < NR; i++)
          if (w < 0 && elig[(m_ptr + i) % NR]) w = (m_ptr + i) % NR;
        m_gnt = 1 << w;
        m_rnd = q_buf.pop_front();
        m_ptr = (w + 1) % NR;
        m_gc = (m_gc + 1) & 16'hffff;
        m_since++;
      end
      if (m_mode == 2 && s_done) begin
        if (q_buf.size() > 0) void'(q_buf.pop_front());
        q_buf.push_back(int'(s_pd));
      end
      if (m_mode == 1) begin
        q_buf.delete(); m_seeded = 1; m_since = 0; m_mode = 2;
      end
      if (hs != 0) begin
        m_base = int'(s_sd); m_idx = 0; m_mode = 1;
        m_lseed = s_sd == 0 ? 1 : int'(s_sd);
      end else if (ars != 0) begin
        m_idx++; m_mode = 1;
        m_lseed = (m_base + m_idx) & 255;
        if (m_lseed == 0) m_lseed = 1;
      end
    end
  endtask
  task automatic tick();
    logic s_reset, s_sv, s_load, s_done;
    logic [N-1:0] s_sd, s_pd, s_sdata;
    logic [NR-1:0] s_req;
    bit en;
    s_reset = reset; s_sv = bus.seed_valid; s_sd = bus.seed_data; s_req = bus.req;
    s_done = core_prng_done; s_pd = core_prng_data; s_load = core_load_seed; s_sdata = core_seed_data;
    @(posedge clk);
    #1;
    model_edge(s_reset, s_sv, s_sd, s_req, s_done, s_pd);
    cyc++;
    en = done_every > 0 ? (cyc % done_every == 0) : ($urandom_range(0, 99) < 60);
    if (s_load === 1'b1) begin
      c_state = int'(s_sdata);
      core_prng_done = 1'b0;
    end else begin
      if (en) c_state = lcg(c_state);
      core_prng_done = en;
    end
    core_prng_data = N'(c_state);
    if (bus.gnt != 0) got.push_back(int'(bus.rnd_data));
    if (core_load_seed) loads.push_back(int'(core_seed_data));
    check("gnt", bus.gnt, m_gnt);
    check("rnd_data", bus.rnd_data, m_rnd);
    check("grant_count", grant_count, m_gc);
    check("seeded", seeded, m_seeded);
    check("seed_ready", bus.seed_ready, reset ? 0 : int'(m_mode != 1));
    check("core_load_seed", core_load_seed, int'(m_mode == 1));
    check("core_seed_data", core_seed_data, m_mode == 1 ? m_lseed : 0);
  endtask
  task automatic give_seed(input int s);
    int t;
    t = 0;
    while (!bus.seed_ready && t < 10) begin
      tick();
      t++;
    end
    check("seed_ready_wait", bus.seed_ready, 1);
    bus.seed_valid = 1'b1;
    bus.seed_data = N'(s);
    tick();
    bus.seed_valid = 1'b0;
  endtask
  initial begin
    int k, x, last, n_rr, t;
    logic [NR-1:0] pend;
    reset = 1'b1; bus.seed_valid = 1'b0; bus.seed_data = '0; bus.req = '0;
    core_prng_done = 1'b0; core_prng_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    bus.req = 4'b0001;
    got.delete();
    repeat (20) tick();
    check("no_seed_gnts", got.size(), 0);
    check("no_seed_seeded", seeded, 0);
    done_every = 4;
    loads.delete();
    got.delete();
    give_seed(42);
    repeat (40) tick();
    check("load_first", loads.size() > 0 ? loads[0] : -1, 42);
    k = got.size() < RP ? got.size() : RP;
    check("seq_len", k >= 4, 1);
    x = 42;
    for (int i = 0; i < k; i++) begin
      x = lcg(x);
      check("seq", got[i], x);
    end
    done_every = 1;
    bus.req = 4'b1111;
    last = 0;
    n_rr = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus.gnt != 0) begin
        if (last != 0) check("rr_order", bus.gnt, ((last << 1) | (last >> 3)) & 15);
        last = int'(bus.gnt);
        n_rr++;
      end
    end
    check("rr_grants", n_rr >= 8, 1);
    bus.req = '0;
    repeat (6) tick();
    t = 0;
    while (!bus.seed_ready && t < 10) begin
      tick();
      t++;
    end
    bus.req = 4'b0100;
    bus.seed_valid = 1'b1;
    bus.seed_data = 8'd77;
    tick();
    bus.seed_valid = 1'b0;
    check("hs_no_gnt", bus.gnt, 0);
    check("hs_load", core_load_seed, 1);
    check("hs_seed", core_seed_data, 77);
    t = 0;
    while (bus.gnt == 0 && t < 10) begin
      tick();
      t++;
    end
    check("hs_regrant", bus.gnt, 4'b0100);
    bus.req = '0;
    tick();
    give_seed(0);
    check("zero_seed", core_seed_data, 1);
    check("zero_load", core_load_seed, 1);
`ifdef PRNG_ARB_RESEED_EN
    loads.delete();
    bus.req = 4'b0001;
    give_seed(42);
    repeat (40) tick();
    check("auto_load0", loads.size() > 0 ? loads[0] : -1, 42);
    check("auto_load1", loads.size() > 1 ? loads[1] : -1, 43);
    check("auto_load2", loads.size() > 2 ? loads[2] : -1, 44);
    bus.req = '0;
`endif
    done_every = 0;
    pend = '0;
    for (int i = 0; i < 1500; i++) begin
      pend = pend & ~bus.gnt;
      pend = pend | NR'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus.req = pend;
      reset = ($urandom_range(0, 399) == 0);
      bus.seed_valid = ($urandom_range(0, 99) < 2);
      bus.seed_data = N'($urandom);
      tick();
    end
    reset = 1'b0;
    bus.seed_valid = 1'b0;
    bus.req = '0;
    give_seed(9);
    bus.req = 4'b1111;
    done_every = 1;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check("rst_gnt", bus.gnt, 0);
    check("rst_gc", grant_count, 0);
    check("rst_seeded", seeded, 0);
    check("rst_ready", bus.seed_ready, 0);
    check("rst_load", core_load_seed, 0);
    reset = 1'b0;
    bus.req = '0;
    tick();
    check("post_rst_ready", bus.seed_ready, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
